multicycle_controller: RTL and testbench

- Control FSM for the multi-cycle MIPS datapath. One shared memory serves instruction fetch and data access, and one ALU serves PC increment, address calculation and execution.
- Sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction. Generates all datapath enables and mux selects, plus ALU control.
- Stalls on a memory-ready handshake.
- Flags unsupported opcodes/functs and resumes at the next fetch.

---
 rtl/multicycle_controller.sv | 253 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for a multi-cycle MIPS datapath with a shared memory and a
// shared ALU. It steps each instruction through fetch, decode, execute,
// memory and writeback, and produces every datapath enable, mux select and
// ALU control. Memory states wait on mem_ready. Unsupported opcodes and
// functs raise a one-cycle illegal pulse, and the machine resumes at fetch.
//
// Ports:
//   clk, resetn         clock (rising edge), asynchronous active-low reset
//   op, funct           instruction fields from the instruction register
//   zero                ALU zero flag, used only for branch PC enable
//   mem_ready           memory completes the current access this cycle
//   mem_req, iord       memory access active, address select (1 = ALUOut)
//   memwrite, irwrite   memory write strobe, instruction register load
//   regdst, memtoreg    write register select, write-back data select
//   regwrite            register file write
//   alusrca, alusrcb    ALU operand selects
//   pcsrc, pcen         next-PC select, PC register enable
//   alucont             ALU operation
//   illegal             one-cycle pulse on an unsupported instruction
//   state               current state, for debug
module multicycle_controller #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic               pcen,
    output logic [2:0]         alucont,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'd0,
        AOP_SUB   = 2'd1,
        AOP_FUNCT = 2'd2
    } aluop_t;

    state_t     state_q;
    state_t     state_d;
    aluop_t     aluop;
    logic       pcwrite;
    logic       branch;
    logic [2:0] funct_alucont;
    logic       funct_ok;

    // State register; reset returns to fetch immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // R-type funct decode; unsupported functs fall back to add and are flagged.
    always_comb begin
        funct_alucont = ALU_ADD;
        funct_ok      = 1'b1;
        case (funct)
            FN_ADD:  funct_alucont = ALU_ADD;
            FN_SUB:  funct_alucont = ALU_SUB;
            FN_AND:  funct_alucont = ALU_AND;
            FN_OR:   funct_alucont = ALU_OR;
            FN_SLT:  funct_alucont = ALU_SLT;
            default: funct_ok      = 1'b0;
        endcase
    end

    // Next state and Moore output decode.
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        illegal  = 1'b0;
        aluop    = AOP_ADD;

        case (state_q)
            S_FETCH: begin
                // PC + 4 through the ALU; IR and PC commit only when the read lands.
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut.
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                // The strobe is qualified by mem_ready so a stall never writes.
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = mem_ready;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = AOP_FUNCT;
                state_d = funct_ok ? S_RTYPEWB : S_ILLEGAL;
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = AOP_SUB;
                branch  = 1'b1;
                pcsrc   = 2'b01;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        case (aluop)
            AOP_SUB:   alucont = ALU_SUB;
            AOP_FUNCT: alucont = funct_alucont;
            default:   alucont = ALU_ADD;
        endcase

        pcen = pcwrite | (branch & zero);

        // Quiet, side-effect-free outputs while reset is asserted.
        if (!resetn) begin
            mem_req  = 1'b0;
            iord     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            regwrite = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = 2'b01;
            pcsrc    = 2'b00;
            pcen     = 1'b0;
            alucont  = ALU_ADD;
            illegal  = 1'b0;
        end
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a vector table of instructions with their
// expected state walks, plus hand-written stall and reset sequences. Each
// cycle pushes the expected output record to a scoreboard and pops it when
// the outputs are sampled.
module tb_multicycle_controller;

    localparam int unsigned STATE_W = 4;

    logic               clk = 1'b0;
    logic               resetn;
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               mem_ready;
    logic               mem_req;
    logic               iord;
    logic               memwrite;
    logic               irwrite;
    logic               regdst;
    logic               memtoreg;
    logic               regwrite;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic               pcen;
    logic [2:0]         alucont;
    logic               illegal;
    logic [STATE_W-1:0] state;

    multicycle_controller #(.STATE_W(STATE_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .iord      (iord),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .pcen      (pcen),
        .alucont   (alucont),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [2:0] alucont;
        logic       illegal;
        logic [3:0] state;
    } out_t;

    typedef struct packed {
        logic [5:0]      op;
        logic [5:0]      funct;
        logic            zero;
        logic [2:0]      ncyc;
        logic [5:0][3:0] seq;
    } vec_t;

    out_t act;
    assign act = {mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                  alusrca, alusrcb, pcsrc, pcen, alucont, illegal, 4'(state)};

    out_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[13];

    int lw_s  [8] = '{0, 0, 0, 1, 2, 3, 3, 4};
    int lw_mr [8] = '{0, 0, 1, 1, 1, 0, 1, 1};
    int sw_s  [7] = '{0, 1, 2, 5, 5, 5, 5};
    int sw_mr [7] = '{1, 1, 1, 0, 0, 0, 1};

    // Expected outputs for a state, written from the control table.
    function automatic out_t exp_out(input logic [3:0] s, input logic [5:0] fn,
                                     input logic z, input logic mr);
        out_t e;
        e         = '0;
        e.alucont = 3'b010;
        e.state   = s;
        case (s)
            4'd0:  begin e.mem_req = 1'b1; e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
            4'd1:  e.alusrcb = 2'b11;
            4'd2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            4'd3:  begin e.mem_req = 1'b1; e.iord = 1'b1; end
            4'd4:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            4'd5:  begin e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = mr; end
            4'd6: begin
                e.alusrca = 1'b1;
                case (fn)
                    6'b100010: e.alucont = 3'b110;
                    6'b100100: e.alucont = 3'b000;
                    6'b100101: e.alucont = 3'b001;
                    6'b101010: e.alucont = 3'b111;
                    default:   e.alucont = 3'b010;
                endcase
            end
            4'd7:  begin e.regwrite = 1'b1; e.regdst = 1'b1; end
            4'd8:  begin e.alusrca = 1'b1; e.alucont = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
            4'd9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            4'd10: e.regwrite = 1'b1;
            4'd11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            4'd12: e.illegal = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic out_t rst_out();
        out_t e;
        e         = '0;
        e.alusrcb = 2'b01;
        e.alucont = 3'b010;
        return e;
    endfunction

    function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input logic z,
                                input int n, input int s0, input int s1, input int s2,
                                input int s3, input int s4);
        vec_t v;
        v        = '0;
        v.op     = o;
        v.funct  = f;
        v.zero   = z;
        v.ncyc   = 3'(n);
        v.seq[0] = 4'(s0);
        v.seq[1] = 4'(s1);
        v.seq[2] = 4'(s2);
        v.seq[3] = 4'(s3);
        v.seq[4] = 4'(s4);
        return v;
    endfunction

    task automatic compare(input string name);
        out_t e;
        e = sb_q.pop_front();
        n_checks++;
        if (act === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
                     name, act.state, act, e.state, e);
        end
    endtask

    // One cycle: drive at the falling edge, check 1 ns later, advance.
    task automatic step(input logic [3:0] es, input logic mr, input logic z,
                        input string name);
        mem_ready = mr;
        zero      = z;
        sb_q.push_back(exp_out(es, funct, z, mr));
        #1 compare(name);
        @(negedge clk);
    endtask

    initial begin
        resetn    = 1'b0;
        op        = 6'b000000;
        funct     = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;

        vecs[0]  = mk(6'b100011, 6'b000000, 1'b0, 5, 0, 1, 2, 3, 4);
        vecs[1]  = mk(6'b101011, 6'b000000, 1'b0, 4, 0, 1, 2, 5, 0);
        vecs[2]  = mk(6'b000000, 6'b100000, 1'b0, 4, 0, 1, 6, 7, 0);
        vecs[3]  = mk(6'b000000, 6'b100010, 1'b1, 4, 0, 1, 6, 7, 0);
        vecs[4]  = mk(6'b000000, 6'b100100, 1'b0, 4, 0, 1, 6, 7, 0);
        vecs[5]  = mk(6'b000000, 6'b100101, 1'b0, 4, 0, 1, 6, 7, 0);
        vecs[6]  = mk(6'b000000, 6'b101010, 1'b0, 4, 0, 1, 6, 7, 0);
        vecs[7]  = mk(6'b000000, 6'b000111, 1'b0, 4, 0, 1, 6, 12, 0);
        vecs[8]  = mk(6'b000100, 6'b000000, 1'b1, 3, 0, 1, 8, 0, 0);
        vecs[9]  = mk(6'b000100, 6'b000000, 1'b0, 3, 0, 1, 8, 0, 0);
        vecs[10] = mk(6'b001000, 6'b000000, 1'b0, 4, 0, 1, 9, 10, 0);
        vecs[11] = mk(6'b000010, 6'b000000, 1'b0, 3, 0, 1, 11, 0, 0);
        vecs[12] = mk(6'b111111, 6'b000000, 1'b0, 3, 0, 1, 12, 0, 0);

        // Reset state with memory ready.
        @(negedge clk);
        sb_q.push_back(rst_out());
        #1 compare("reset_hold");
        @(negedge clk);
        resetn = 1'b1;

        // Vector table with mem_ready tied high.
        for (int i = 0; i < 13; i++) begin
            op    = vecs[i].op;
            funct = vecs[i].funct;
            for (int c = 0; c < int'(vecs[i].ncyc); c++) begin
                step(vecs[i].seq[c], 1'b1, vecs[i].zero, $sformatf("vec%0d_cyc%0d", i, c));
            end
        end

        // LW with stalls in both fetch and the data read.
        op    = 6'b100011;
        funct = 6'b000000;
        for (int c = 0; c < 8; c++) begin
            step(4'(lw_s[c]), 1'(lw_mr[c]), 1'b0, $sformatf("lw_stall_cyc%0d", c));
        end

        // SW held off for three cycles in the write state.
        op = 6'b101011;
        for (int c = 0; c < 7; c++) begin
            step(4'(sw_s[c]), 1'(sw_mr[c]), 1'b0, $sformatf("sw_stall_cyc%0d", c));
        end
        step(4'd0, 1'b1, 1'b0, "sw_stall_return_fetch");

        // Reset asserted in the write state with memory ready: no strobe escapes.
        op = 6'b101011;
        step(4'd1, 1'b1, 1'b0, "rstmid_decode");
        step(4'd2, 1'b1, 1'b0, "rstmid_memadr");
        mem_ready = 1'b1;
        resetn    = 1'b0;
        sb_q.push_back(rst_out());
        #1 compare("rstmid_assert");
        @(negedge clk);
        sb_q.push_back(rst_out());
        #1 compare("rstmid_held");
        @(negedge clk);
        resetn = 1'b1;
        step(4'd0, 1'b1, 1'b0, "rstmid_post_fetch");
        step(4'd1, 1'b1, 1'b0, "rstmid_post_decode");
        step(4'd2, 1'b1, 1'b0, "rstmid_post_memadr");
        step(4'd5, 1'b1, 1'b0, "rstmid_post_memwr");
        step(4'd0, 1'b1, 1'b0, "rstmid_post_return");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
